instr_mem_responder: RTL and testbench

Memory-side responder for the instruction cache's block-fill protocol. It accepts a single-beat block request (address + valid), waits a fixed access latency, then streams one block as NUM_BEATS back-to-back data beats with a valid strobe. It sits opposite the cache's memory controller and serves as the synthesizable backing-memory model for integration and bring-up, with a preload write port for the bench or boot loader.

---
 rtl/instr_cache_pkg.sv | 26 ++
 rtl/mem_resp_storage.sv | 28 ++
 rtl/instr_mem_responder.sv | 109 ++++++++++
 tb/tb_instr_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// Shared instruction-cache definitions: block-fill geometry, responder timing,
// responder state encoding and the beat payload type.
package instr_cache_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned NUM_BEATS  = 10;
  localparam int unsigned LATENCY    = 4;
  localparam int unsigned DEPTH      = 1024;

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned BEAT_W = $clog2(NUM_BEATS) + 1;
  localparam int unsigned LAT_W  = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } mem_beat_t;

endpackage

// File: rtl/mem_resp_storage.sv
// Backing storage for the block-fill responder: DEPTH words, one synchronous
// write port, one asynchronous read port. Addresses wrap modulo DEPTH.
module mem_resp_storage
  import instr_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      wr_idx_c;
  logic [IDX_W-1:0]      rd_idx_c;

  assign wr_idx_c = IDX_W'(32'(wr_addr_i) % DEPTH);
  assign rd_idx_c = IDX_W'(32'(rd_addr_i) % DEPTH);

  // Not reset: contents survive arst_n so preloaded images persist.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_c] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_c];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the I-cache block fill: one request, fixed latency,
// then NUM_BEATS back-to-back beats. Define MEM_RESP_OVERRUN_FLAG_EN to add the
// sticky o_req_overrun output flagging requests dropped while busy.
module instr_mem_responder
  import instr_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [ADDR_WIDTH-1:0] i_mem_req_addr,
  input  logic                  i_mem_req_valid,
  input  logic                  i_mem_ready,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_req_ready,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_data_valid,
  output logic                  o_busy
`ifdef MEM_RESP_OVERRUN_FLAG_EN
  ,
  output logic                  o_req_overrun
`endif
);

  resp_state_e           state_q;
  logic [LAT_W-1:0]      lat_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  mem_beat_t             beat_q;

  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic [DATA_WIDTH-1:0] rd_data_c;

  // Beat k reads addr + k; the storage folds the sum modulo DEPTH.
  assign rd_addr_c = addr_q + ADDR_WIDTH'(beat_cnt_q);

  mem_resp_storage u_storage (
    .clk       (clk),
    .wr_en_i   (i_wr_en),
    .wr_addr_i (i_wr_addr),
    .wr_data_i (i_wr_data),
    .rd_addr_i (rd_addr_c),
    .rd_data_o (rd_data_c)
  );

  // Beat 0 is registered on the WAIT->STREAM edge; STREAM returns to IDLE on the
  // edge after the last beat, so ready rises exactly as valid falls.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
    end else begin
      beat_q <= '0;
      case (state_q)
        IDLE: begin
          if (i_mem_req_valid) begin
            addr_q     <= i_mem_req_addr;
            lat_q      <= LAT_W'(LATENCY - 1);
            beat_cnt_q <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - LAT_W'(1);
          end else if (i_mem_ready) begin
            beat_q     <= '{valid: 1'b1, data: rd_data_c};
            beat_cnt_q <= BEAT_W'(1);
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (beat_cnt_q == BEAT_W'(NUM_BEATS)) begin
            beat_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            beat_q     <= '{valid: 1'b1, data: rd_data_c};
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_req_ready      = (state_q == IDLE);
  assign o_busy           = (state_q != IDLE);
  assign o_mem_data       = beat_q.data;
  assign o_mem_data_valid = beat_q.valid;

`ifdef MEM_RESP_OVERRUN_FLAG_EN
  logic overrun_q;

  // Sticky until reset: a request arrived while a fill was in progress.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overrun_q <= 1'b0;
    end else if (i_mem_req_valid && (state_q != IDLE)) begin
      overrun_q <= 1'b1;
    end
  end

  assign o_req_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: timeline model of the block-fill
// protocol checked every cycle, plus literal checks of the directed scenarios.
module tb_instr_mem_responder;
  import instr_cache_pkg::*;

  localparam int L  = int'(LATENCY);
  localparam int N  = int'(NUM_BEATS);
  localparam int DP = int'(DEPTH);

  logic                  clk;
  logic                  arst_n;
  logic [ADDR_WIDTH-1:0] i_mem_req_addr;
  logic                  i_mem_req_valid;
  logic                  i_mem_ready;
  logic                  i_wr_en;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_req_ready;
  logic [DATA_WIDTH-1:0] o_mem_data;
  logic                  o_mem_data_valid;
  logic                  o_busy;
`ifdef MEM_RESP_OVERRUN_FLAG_EN
  logic                  o_req_overrun;
`endif

  instr_mem_responder dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .i_mem_req_addr   (i_mem_req_addr),
    .i_mem_req_valid  (i_mem_req_valid),
    .i_mem_ready      (i_mem_ready),
    .i_wr_en          (i_wr_en),
    .i_wr_addr        (i_wr_addr),
    .i_wr_data        (i_wr_data),
    .o_req_ready      (o_req_ready),
    .o_mem_data       (o_mem_data),
    .o_mem_data_valid (o_mem_data_valid),
    .o_busy           (o_busy)
`ifdef MEM_RESP_OVERRUN_FLAG_EN
    ,
    .o_req_overrun    (o_req_overrun)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is accepted at edge a when idle, its first beat
  // lands on the first edge >= a+L with ready high, beats run N edges, and the
  // responder is idle again from edge start+N onward.
  logic [31:0] mmem [DEPTH];
  int  mcyc    = 0;
  bit  m_busy  = 1'b0;
  int  m_acc   = 0;
  int  m_start = -1;
  int  m_addr  = 0;
  bit  m_ovr   = 1'b0;
  bit  e_valid = 1'b0;
  logic [31:0] e_data = '0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_busy  = 1'b0;
      m_start = -1;
      m_ovr   = 1'b0;
      e_valid = 1'b0;
      e_data  = '0;
    end else begin
      mcyc++;
      if (m_busy) begin
        if (m_start < 0 && mcyc >= m_acc + L && i_mem_ready) m_start = mcyc;
        if (m_start >= 0 && mcyc - m_start < N) begin
          e_valid = 1'b1;
          e_data  = mmem[(m_addr + mcyc - m_start) % DP];
        end else begin
          e_valid = 1'b0;
          e_data  = '0;
        end
        if (m_start >= 0 && mcyc - m_start >= N) m_busy = 1'b0;
        if (i_mem_req_valid) m_ovr = 1'b1;
      end else begin
        e_valid = 1'b0;
        e_data  = '0;
        if (i_mem_req_valid) begin
          m_busy  = 1'b1;
          m_acc   = mcyc;
          m_start = -1;
          m_addr  = int'(i_mem_req_addr);
        end
      end
      if (i_wr_en) mmem[int'(i_wr_addr) % DP] = i_wr_data;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 32'(o_mem_data_valid), 32'(e_valid));
      chk("m_data", o_mem_data, e_data);
      chk("m_ready", 32'(o_req_ready), 32'(!m_busy));
      chk("m_busy", 32'(o_busy), 32'(m_busy));
`ifdef MEM_RESP_OVERRUN_FLAG_EN
      chk("m_overrun", 32'(o_req_overrun), 32'(m_ovr));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request at edge 0; ready held low until ready_edge; optional extra request
  // at extra_edge. Literal checks: beats base+k on edges first..first+N-1.
  task automatic timeline(input logic [15:0] addr, input int ready_edge,
                          input int extra_edge, input logic [31:0] base);
    int  first;
    bit  ev;
    first = (ready_edge > L) ? ready_edge : L;
    i_mem_req_addr  = addr;
    i_mem_req_valid = 1'b1;
    i_mem_ready     = (ready_edge <= 0);
    tick();
    i_mem_req_valid = 1'b0;
    for (int k = 1; k <= first + N + 1; k++) begin
      i_mem_ready     = (k >= ready_edge);
      i_mem_req_valid = (k == extra_edge);
      i_mem_req_addr  = addr ^ 16'h0055;
      tick();
      ev = (k >= first) && (k < first + N);
      chk("tl_valid", 32'(o_mem_data_valid), 32'(ev));
      chk("tl_data", o_mem_data, ev ? base + 32'(k - first) : 32'h0);
      chk("tl_ready", 32'(o_req_ready), 32'(k >= first + N));
    end
    i_mem_req_valid = 1'b0;
    i_mem_ready     = 1'b1;
  endtask

  // Burst from 0x200; beat 2 lands on edge L+2, optionally with a write to it.
  task automatic rbw_pass(input bit do_write, input logic [31:0] exp2);
    i_mem_req_addr  = 16'h0200;
    i_mem_req_valid = 1'b1;
    i_mem_ready     = 1'b1;
    tick();
    i_mem_req_valid = 1'b0;
    for (int k = 1; k <= L + N + 1; k++) begin
      i_wr_en   = do_write && (k == L + 2);
      i_wr_addr = 16'h0202;
      i_wr_data = 32'hDEAD_BEEF;
      tick();
      if (k == L + 2) chk("rbw_beat2", o_mem_data, exp2);
    end
    i_wr_en = 1'b0;
  endtask

  logic [31:0] pdata;
  logic [31:0] old202;

  initial begin
    arst_n          = 1'b0;
    i_mem_req_addr  = '0;
    i_mem_req_valid = 1'b0;
    i_mem_ready     = 1'b1;
    i_wr_en         = 1'b0;
    i_wr_addr       = '0;
    i_wr_data       = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(o_req_ready), 32'h1);
    chk("rst_data", o_mem_data, 32'h0);
    chk("rst_valid", 32'(o_mem_data_valid), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
`ifdef MEM_RESP_OVERRUN_FLAG_EN
    chk("rst_overrun", 32'(o_req_overrun), 32'h0);
`endif
    chk_en = 1'b1;
    arst_n = 1'b1;

    // Preload every word; two recognisable windows for the directed bursts.
    for (int w = 0; w < DP; w++) begin
      pdata = $urandom;
      if (w >= 'h100 && w <= 'h109) pdata = 32'hA000_0000 + 32'(w - 'h100);
      if (w >= 'h3FE)               pdata = 32'hB000_0000 + 32'(w - 'h3FE);
      if (w <= 7)                   pdata = 32'hB000_0002 + 32'(w);
      i_wr_en   = 1'b1;
      i_wr_addr = 16'(w);
      i_wr_data = pdata;
      tick();
    end
    i_wr_en = 1'b0;
    tick();

    timeline(16'h0100, 0, -1, 32'hA000_0000);
    timeline(16'h03FE, 0, -1, 32'hB000_0000);
    timeline(16'h0100, 7, -1, 32'hA000_0000);
    timeline(16'h0100, 0, 6, 32'hA000_0000);
`ifdef MEM_RESP_OVERRUN_FLAG_EN
    chk("overrun_set", 32'(o_req_overrun), 32'h1);
`endif
    timeline(16'h03FE, 0, -1, 32'hB000_0000);

    old202 = mmem[16'h0202];
    rbw_pass(1'b1, old202);
    rbw_pass(1'b0, 32'hDEAD_BEEF);

    // Reset while beat 5 is on the bus, then a clean burst.
    i_mem_req_addr  = 16'h0100;
    i_mem_req_valid = 1'b1;
    tick();
    i_mem_req_valid = 1'b0;
    for (int k = 1; k <= L + 5; k++) tick();
    chk("mid_beat5", o_mem_data, 32'hA000_0005);
    #2 arst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_mem_data_valid), 32'h0);
    chk("mid_rst_data", o_mem_data, 32'h0);
    chk("mid_rst_ready", 32'(o_req_ready), 32'h1);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
`ifdef MEM_RESP_OVERRUN_FLAG_EN
    chk("mid_rst_overrun", 32'(o_req_overrun), 32'h0);
`endif
    tick();
    arst_n = 1'b1;
    timeline(16'h0100, 0, -1, 32'hA000_0000);

    // Random traffic around the wrap point, upper address bits scrambled.
    for (int c = 0; c < 800; c++) begin
      i_mem_req_valid = ($urandom_range(0, 4) == 0);
      i_mem_req_addr  = {6'($urandom), 10'($urandom_range(1000, 1031))};
      i_mem_ready     = ($urandom_range(0, 3) != 0);
      i_wr_en         = ($urandom_range(0, 2) == 0);
      i_wr_addr       = {6'($urandom), 10'($urandom_range(1000, 1031))};
      i_wr_data       = $urandom;
      tick();
    end
    i_mem_req_valid = 1'b0;
    i_wr_en         = 1'b0;
    i_mem_ready     = 1'b1;
    repeat (L + N + 30) tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
